// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer: instruction-fetch front end between the Icache and decode.
// Requests 32B lines over a two-phase toggle handshake, captures each returned
// line, and hands its 32-bit words to decode one at a time over valid/ready.
// Branch redirects restart fetch; a line already in flight is acked and dropped.
module ifu_fetch_buffer #(
    parameter int              PA_W        = 34,
    parameter int              SYNC_STAGES = 2,
    parameter logic [PA_W-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_redirect_valid,
    input  logic [PA_W-1:0] i_redirect_pc,
    output logic [PA_W-1:0] o_fetch_pa,
    output logic            o_req_toggle,
    input  logic            i_req_ack_toggle,
    input  logic            i_line_toggle,
    output logic            o_line_ack_toggle,
    input  logic [255:0]    i_line_data,
    output logic            o_inst_valid,
    output logic [31:0]     o_inst,
    output logic [PA_W-1:0] o_inst_pc,
    input  logic            i_inst_ready
);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    localparam logic [PA_W-6:0] LINE_ONE = 1;

    logic [SYNC_STAGES-1:0] reqAckSync_q, lineSync_q;
    logic                   reqAckPrev_q, linePrev_q;
    logic                   reqAckEvt, lineEvt;

    logic [1:0]      state_q, state_d;
    logic [PA_W-1:2] pc_q, pc_d;
    logic [2:0]      slot_q, slot_d;
    logic [255:0]    line_q, line_d;
    logic            reqTog_q, reqTog_d;
    logic            lineAck_q, lineAck_d;
    logic [PA_W-1:0] fetchPa_q, fetchPa_d;
    logic            reqAcked_q, reqAcked_d;
    logic            instValid_q, instValid_d;
    logic [31:0]     inst_q, inst_d;
    logic [PA_W-1:0] instPc_q, instPc_d;
    logic            transfer;

    // Redirect targets are word aligned; the byte offset carries no information.
    logic unusedBits;
    assign unusedBits = ^i_redirect_pc[1:0];

    assign reqAckEvt = reqAckSync_q[SYNC_STAGES-1] ^ reqAckPrev_q;
    assign lineEvt   = lineSync_q[SYNC_STAGES-1] ^ linePrev_q;
    assign transfer  = instValid_q & i_inst_ready;

    // Bring the Icache toggles into this clock domain and keep the last value for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reqAckSync_q <= '0;
            lineSync_q   <= '0;
            reqAckPrev_q <= 1'b0;
            linePrev_q   <= 1'b0;
        end else begin
            reqAckSync_q <= {reqAckSync_q[SYNC_STAGES-2:0], i_req_ack_toggle};
            lineSync_q   <= {lineSync_q[SYNC_STAGES-2:0], i_line_toggle};
            reqAckPrev_q <= reqAckSync_q[SYNC_STAGES-1];
            linePrev_q   <= lineSync_q[SYNC_STAGES-1];
        end
    end

    // Fetch sequencing; a redirect overrides whatever the current state would have done.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        slot_d     = slot_q;
        line_d     = line_q;
        reqTog_d   = reqTog_q;
        lineAck_d  = lineAck_q;
        fetchPa_d  = fetchPa_q;
        reqAcked_d = reqAcked_q | reqAckEvt;

        case (state_q)
            S_REQ: begin
                reqTog_d   = ~reqTog_q;
                fetchPa_d  = {pc_q[PA_W-1:5], 5'b00000};
                reqAcked_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (lineEvt) begin
                    line_d    = i_line_data;
                    lineAck_d = ~lineAck_q;
                    slot_d    = pc_q[4:2];
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (transfer) begin
                    if (slot_q == 3'd7) begin
                        pc_d    = {pc_q[PA_W-1:5] + LINE_ONE, 3'b000};
                        state_d = S_REQ;
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            default: begin
                if (lineEvt) begin
                    lineAck_d = ~lineAck_q;
                    state_d   = S_REQ;
                end
            end
        endcase

        if (i_redirect_valid) begin
            pc_d = i_redirect_pc[PA_W-1:2];
            case (state_q)
                S_REQ, S_DRAIN: begin
                    reqTog_d   = reqTog_q;
                    fetchPa_d  = fetchPa_q;
                    reqAcked_d = reqAcked_q | reqAckEvt;
                    state_d    = S_REQ;
                end
                S_WAIT: begin
                    // A line landing in the redirect cycle is acked and dropped here,
                    // otherwise its event would be consumed and DISCARD would never leave.
                    line_d  = line_q;
                    slot_d  = slot_q;
                    state_d = lineEvt ? S_REQ : S_DISCARD;
                end
                default: begin
                end
            endcase
        end
    end

    // Decode-side outputs are registered from the next slot so a transfer advances them at once.
    always_comb begin
        instValid_d = (state_q == S_DRAIN) && !i_redirect_valid &&
                      !(transfer && (slot_q == 3'd7));
        inst_d      = inst_q;
        instPc_d    = instPc_q;
        if (instValid_d) begin
            inst_d   = line_q[{slot_d, 5'b00000} +: 32];
            instPc_d = {pc_q[PA_W-1:5], slot_d, 2'b00};
        end
    end

    // State and output registers, all cleared by the shared async reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC[PA_W-1:2];
            slot_q      <= 3'd0;
            line_q      <= '0;
            reqTog_q    <= 1'b0;
            lineAck_q   <= 1'b0;
            fetchPa_q   <= {RESET_PC[PA_W-1:5], 5'b00000};
            reqAcked_q  <= 1'b0;
            instValid_q <= 1'b0;
            inst_q      <= '0;
            instPc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            slot_q      <= slot_d;
            line_q      <= line_d;
            reqTog_q    <= reqTog_d;
            lineAck_q   <= lineAck_d;
            fetchPa_q   <= fetchPa_d;
            reqAcked_q  <= reqAcked_d;
            instValid_q <= instValid_d;
            inst_q      <= inst_d;
            instPc_q    <= instPc_d;
        end
    end

    assign o_fetch_pa        = fetchPa_q;
    assign o_req_toggle      = reqTog_q;
    assign o_line_ack_toggle = lineAck_q;
    assign o_inst_valid      = instValid_q;
    assign o_inst            = inst_q;
    assign o_inst_pc         = instPc_q;

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// tb_ifu_fetch_buffer: directed bench for ifu_fetch_buffer with a toggle-handshake
// Icache responder and a scoreboard of expected decode transfers.
module tb_ifu_fetch_buffer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         i_redirect_valid;
    logic [33:0]  i_redirect_pc;
    logic [33:0]  o_fetch_pa;
    logic         o_req_toggle;
    logic         i_req_ack_toggle;
    logic         i_line_toggle;
    logic         o_line_ack_toggle;
    logic [255:0] i_line_data = '0;
    logic         o_inst_valid;
    logic [31:0]  o_inst;
    logic [33:0]  o_inst_pc;
    logic         i_inst_ready;

    typedef struct packed {
        logic [33:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          nAsserts = 0;
    int          nFails   = 0;
    int          reqCount = 0;
    int          ackCount = 0;
    logic [33:0] lastPa   = '0;

    always #5 clk = ~clk;

    ifu_fetch_buffer dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_fetch_pa       (o_fetch_pa),
        .o_req_toggle     (o_req_toggle),
        .i_req_ack_toggle (i_req_ack_toggle),
        .i_line_toggle    (i_line_toggle),
        .o_line_ack_toggle(o_line_ack_toggle),
        .i_line_data      (i_line_data),
        .o_inst_valid     (o_inst_valid),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .i_inst_ready     (i_inst_ready)
    );

    // The Icache returns word k of the line at pa as {pa[33:5], k}.
    function automatic logic [255:0] makeLine(input logic [33:0] pa);
        logic [255:0] l;
        logic [2:0]   kk;
        l = '0;
        for (int k = 0; k < 8; k++) begin
            kk = 3'(k);
            l[32*k +: 32] = {pa[33:5], kk};
        end
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [33:0] target);
        i_redirect_pc    = target;
        i_redirect_valid = 1'b1;
        tick();
        i_redirect_valid = 1'b0;
    endtask

    // Expected words run from startPc to the end of its line; word value is pc[33:2].
    task automatic pushLine(input logic [33:0] startPc);
        logic [33:0] p;
        exp_t        e;
        p = startPc;
        do begin
            e.pc   = p;
            e.inst = p[33:2];
            sb.push_back(e);
            p = p + 34'd4;
        end while (p[4:0] != 5'd0);
    endtask

    task automatic waitReq(input int target, input string tag);
        int b;
        b = 0;
        while (reqCount < target && b < 200) begin
            tick();
            b++;
        end
        checkOutput(tag, 64'(reqCount), 64'(target));
    endtask

    task automatic waitDrain(input string tag);
        int b;
        b = 0;
        while (sb.size() != 0 && b < 300) begin
            tick();
            b++;
        end
        i_inst_ready = 1'b0;
        checkOutput(tag, 64'(sb.size()), 64'd0);
    endtask

    // Icache responder: acks each request, returns the line three cycles later, waits for the ack.
    initial begin
        logic        reqSeen, ackSeen, busy, lineGiven;
        int          cnt;
        logic [33:0] pendPa;
        reqSeen = 1'b0; ackSeen = 1'b0; busy = 1'b0; lineGiven = 1'b0; cnt = 0; pendPa = '0;
        i_req_ack_toggle = 1'b0;
        i_line_toggle    = 1'b0;
        forever begin
            @(negedge clk or negedge rstn);
            if (!rstn) begin
                i_req_ack_toggle = 1'b0;
                i_line_toggle    = 1'b0;
                reqSeen = 1'b0; ackSeen = 1'b0; busy = 1'b0; lineGiven = 1'b0; cnt = 0;
            end else begin
                if (o_line_ack_toggle !== ackSeen) begin
                    checkOutput("ack_without_line", 64'(lineGiven), 64'd1);
                    ackSeen   = o_line_ack_toggle;
                    ackCount++;
                    lineGiven = 1'b0;
                    busy      = 1'b0;
                end
                if (o_req_toggle !== reqSeen) begin
                    checkOutput("req_while_outstanding", 64'(busy), 64'd0);
                    reqSeen = o_req_toggle;
                    reqCount++;
                    lastPa  = o_fetch_pa;
                    pendPa  = o_fetch_pa;
                    busy    = 1'b1;
                    cnt     = 3;
                    i_req_ack_toggle = ~i_req_ack_toggle;
                end else if (busy && !lineGiven) begin
                    cnt--;
                    if (cnt == 0) begin
                        i_line_data   = makeLine(pendPa);
                        i_line_toggle = ~i_line_toggle;
                        lineGiven     = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard: each transfer seen ahead of the edge is matched against the next expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && o_inst_valid === 1'b1 && i_inst_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_inst_pc", 64'(o_inst_pc), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = sb.pop_front();
                    checkOutput("inst_pc", 64'(o_inst_pc), 64'(e.pc));
                    checkOutput("inst", 64'(o_inst), 64'(e.inst));
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        int r;
        int a;
        int b;
        rstn             = 1'b1;
        i_inst_ready     = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        #2 rstn = 1'b0;
        waitCycles(3);

        checkOutput("rst_req_toggle", 64'(o_req_toggle), 64'd0);
        checkOutput("rst_line_ack", 64'(o_line_ack_toggle), 64'd0);
        checkOutput("rst_inst_valid", 64'(o_inst_valid), 64'd0);
        checkOutput("rst_inst", 64'(o_inst), 64'd0);
        checkOutput("rst_inst_pc", 64'(o_inst_pc), 64'd0);
        checkOutput("rst_fetch_pa", 64'(o_fetch_pa), 64'd0);

        $display("[TB] sequential fetch from reset");
        pushLine(34'h0);
        i_inst_ready = 1'b1;
        rstn = 1'b1;
        waitReq(1, "t1_first_req");
        checkOutput("t1_fetch_pa", 64'(lastPa), 64'h0);
        waitDrain("t1_drain");
        waitReq(2, "t1_second_req");
        checkOutput("t1_next_fetch_pa", 64'(lastPa), 64'h20);
        waitCycles(15);

        $display("[TB] redirect to mid-line address while draining");
        r = reqCount;
        applyStimulus(34'h1_0000_0014);
        waitReq(r + 1, "t2_req");
        checkOutput("t2_fetch_pa", 64'(lastPa), 64'h1_0000_0000);
        pushLine(34'h1_0000_0014);
        i_inst_ready = 1'b1;
        waitDrain("t2_drain");
        waitReq(r + 2, "t2_next_req");
        checkOutput("t2_next_fetch_pa", 64'(lastPa), 64'h1_0000_0020);
        waitCycles(15);

        $display("[TB] redirect while a line is in flight");
        r = reqCount;
        applyStimulus(34'h2_0000_0000);
        waitReq(r + 1, "t3_req");
        checkOutput("t3_fetch_pa", 64'(lastPa), 64'h2_0000_0000);
        a = ackCount;
        i_inst_ready = 1'b1;
        applyStimulus(34'h40);
        waitReq(r + 2, "t3_after_discard_req");
        checkOutput("t3_discard_acked", 64'(ackCount), 64'(a + 1));
        checkOutput("t3_fetch_pa_40", 64'(lastPa), 64'h40);
        pushLine(34'h40);

        $display("[TB] decode stall at slot 3");
        b = 0;
        while (sb.size() != 5 && b < 300) begin
            tick();
            b++;
        end
        i_inst_ready = 1'b0;
        checkOutput("t4_reach_slot3", 64'(sb.size()), 64'd5);
        r = reqCount;
        for (int i = 0; i < 10; i++) begin
            checkOutput("t4_hold_valid", 64'(o_inst_valid), 64'd1);
            checkOutput("t4_hold_inst", 64'(o_inst), 64'h13);
            checkOutput("t4_hold_pc", 64'(o_inst_pc), 64'h4C);
            tick();
        end
        checkOutput("t4_no_req_in_stall", 64'(reqCount), 64'(r));
        i_inst_ready = 1'b1;
        waitDrain("t4_drain");
        waitReq(r + 1, "t4_next_req");
        checkOutput("t4_next_fetch_pa", 64'(lastPa), 64'h60);
        waitCycles(15);

        $display("[TB] address wrap at top of physical space");
        r = reqCount;
        applyStimulus(34'h3_FFFF_FFE0);
        waitReq(r + 1, "t5_req");
        checkOutput("t5_fetch_pa", 64'(lastPa), 64'h3_FFFF_FFE0);
        pushLine(34'h3_FFFF_FFE0);
        i_inst_ready = 1'b1;
        waitDrain("t5_drain");
        waitReq(r + 2, "t5_wrap_req");
        checkOutput("t5_wrap_fetch_pa", 64'(lastPa), 64'h0);

        $display("[TB] async reset with a line pending");
        rstn = 1'b0;
        #1;
        checkOutput("t6_rst_req_toggle", 64'(o_req_toggle), 64'd0);
        checkOutput("t6_rst_line_ack", 64'(o_line_ack_toggle), 64'd0);
        checkOutput("t6_rst_inst_valid", 64'(o_inst_valid), 64'd0);
        checkOutput("t6_rst_inst", 64'(o_inst), 64'd0);
        checkOutput("t6_rst_inst_pc", 64'(o_inst_pc), 64'd0);
        checkOutput("t6_rst_fetch_pa", 64'(o_fetch_pa), 64'd0);
        waitCycles(3);
        r = reqCount;
        rstn = 1'b1;
        waitCycles(30);
        checkOutput("t6_one_req_after_reset", 64'(reqCount), 64'(r + 1));
        checkOutput("t6_req_toggle_flipped", 64'(o_req_toggle), 64'd1);
        checkOutput("t6_fetch_pa_reset_pc", 64'(lastPa), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_buffer.md
Name: ifu_fetch_buffer

Overview:
- Clocked instruction-fetch front end that sits directly downstream of the Icache and also drives it.
- Issues 34-bit physical fetch addresses to the Icache over a two-phase (toggle) drive/free handshake.
- Captures each returned 32B line and slices it into eight 32-bit instructions for decode, with a valid/ready interface.
- Handles sequential line advance and branch redirects, including discarding a line that was already in flight when the redirect arrived.

Parameters:
- PA_W, 34, physical address width.
- SYNC_STAGES, 2, flops in each toggle synchronizer (minimum 2).
- RESET_PC, 34'h0, first fetch address after reset.

Ports:
- clk  in  1  core clock.
- rstn  in  1  reset, asynchronous, active-low.
- i_redirect_valid  in  1  one-cycle pulse: flush and restart fetch at i_redirect_pc.
- i_redirect_pc  in  34  redirect target; bits [1:0] are ignored.
- o_fetch_pa  out  34  line address to the Icache, always {pc[33:5],5'b0}; stable while a request is outstanding.
- o_req_toggle  out  1  two-phase request; each toggle is one fetch (Icache i_Itlb_drive).
- i_req_ack_toggle  in  1  two-phase request acceptance (Icache o_Itlb_free).
- i_line_toggle  in  1  two-phase line-ready (Icache o_driveNext_ifu).
- o_line_ack_toggle  out  1  two-phase line consumed (Icache i_freeNext_ifu).
- i_line_data  in  256  returned line (bundled data); stable from the i_line_toggle edge until o_line_ack_toggle.
- o_inst_valid  out  1  instruction available.
- o_inst  out  32  instruction word.
- o_inst_pc  out  34  address of o_inst.
- i_inst_ready  in  1  decode accepts; transfer occurs when o_inst_valid and i_inst_ready.

Behaviour:
- Reset values: o_req_toggle=0, o_line_ack_toggle=0, o_inst_valid=0, o_inst=0, o_inst_pc=0.
  - o_fetch_pa=RESET_PC aligned to 32B.
  - All synchronizer flops and edge-detect registers=0.
  - pc=RESET_PC; state=REQ.
- Synchronization:
  - i_req_ack_toggle and i_line_toggle each pass through SYNC_STAGES flops plus one edge-detect register.
  - An event is recognised when the synchronized value differs from the previous synchronized value.
- FSM states: REQ, WAIT, DRAIN, DISCARD.
- REQ:
  - Toggle o_req_toggle once, with o_fetch_pa={pc[33:5],5'b0} held.
  - Go to WAIT the next cycle.
- WAIT:
  - A line event captures i_line_data into the 256-bit line register and toggles o_line_ack_toggle in the same cycle.
  - Then go to DRAIN with slot=pc[4:2].
  - The request-ack event is recorded only. It must be seen before or together with the line event; a line event without it is still accepted.
- DRAIN:
  - o_inst_valid=1, o_inst=line[32*slot+31 : 32*slot], o_inst_pc={pc[33:5],slot,2'b00}.
  - On each transfer, slot increments.
  - Transfer at slot=7: pc={pc[33:5]+1, 5'b0}, wrapping modulo 2^34, and go to REQ. o_inst_valid drops the following cycle.
  - Without i_inst_ready, all outputs hold.
- First instruction latency after the line toggle edge: SYNC_STAGES+2 cycles.
- Redirect (i_redirect_valid=1) has priority over every other event in the same cycle:
  - pc={i_redirect_pc[33:2],2'b00}; o_inst_valid=0 next cycle.
  - From REQ or DRAIN: go to REQ.
  - From WAIT: go to DISCARD, because a request is outstanding.
  - From DISCARD: stay in DISCARD and update pc only.
  - A transfer in the same cycle as a redirect still counts, since decode sampled it.
- DISCARD:
  - On the line event, toggle o_line_ack_toggle without loading the line register, then go to REQ.
  - At most one request is ever outstanding. Never toggle o_req_toggle before the previous line is acked.
- Redirect to a mid-line address, e.g. pc[4:2]=5: DRAIN starts at slot 5, so only 3 instructions come from that line.
- Async reset mid-operation: return to reset values immediately.
  - Any Icache transaction in flight is abandoned; the Icache is reset by the same rstn.
- No combinational path from i_inst_ready to the toggle outputs. All outputs are registered.

Test Plan:
- Reset, Icache model returns line words 0x00000000..0x00000007 (word k = k) 3 cycles after the request toggle, decode always ready -> o_fetch_pa=0, then o_inst=0..7 with o_inst_pc=0x0,0x4..0x1C, then a second request with o_fetch_pa=0x20.
- Redirect to 0x1_0000_0014 while in DRAIN -> exactly 3 instructions with o_inst_pc 0x1_0000_0014, 0x1_0000_0018, 0x1_0000_001C, using words 5,6,7 of the line fetched at 0x1_0000_0000.
- Redirect to 0x40 during WAIT -> in-flight line acked (o_line_ack_toggle flips) but none of its words appear on o_inst; next request has o_fetch_pa=0x40.
- Decode ready low for 10 cycles in DRAIN at slot 3 -> o_inst/o_inst_pc held constant, no o_req_toggle change, slot 4 follows when ready returns.
- pc line 0x3_FFFF_FFE0 drained -> next o_fetch_pa=0x0 (wrap).
- rstn asserted in WAIT with the Icache toggle pending -> outputs at reset values within the same cycle; after release, o_req_toggle flips once with o_fetch_pa=RESET_PC.
